chien_search_param: RTL
=======================

Name: chien_search_param

Overview:
- Parametrised, handshaked Chien search for the RS decoder.
- Accepts an error-locator polynomial Lambda(x) of degree ≤ T over GF(2^M) from the BM stage.
- Evaluates Lambda at every codeword position in received-symbol order and streams a per-position error flag to the correction stage, with backpressure.
- On completion, reports root count, locator degree and a decode-failure flag. Supports shortened codes (N < 2^M-1).

Parameters:
- M, 8, symbol width / field degree.
- T, 8, max correctable errors; Lambda has T+1 coefficients.
- N, 255, codeword length, 1 ≤ N ≤ 2^M-1.
- PRIM_POLY, 9'h11D, field primitive polynomial, M+1 bits.
- PW, 8, position/count width; must satisfy 2^PW > N.

Ports:
- clk_in  in  1  system clock
- sys_rst  in  1  synchronous, active-high reset
- lambda_in  in  (T+1)*M  Lambda coefficients; bits [k*M +: M] = Lambda_k
- lambda_valid  in  1  lambda_in valid
- lambda_ready  out  1  block can accept a new polynomial
- err_valid  out  1  err_flag/err_pos valid
- out_ready  in  1  downstream accepts current position
- err_flag  out  1  1 = symbol at err_pos is in error
- err_pos  out  PW  received-order position, 0 = first symbol
- done  out  1  one-cycle pulse after the last position is accepted
- root_cnt  out  PW  roots found; valid from done, held until next accept
- lambda_deg  out  4..PW  degree of Lambda; valid as root_cnt
- fail  out  1  uncorrectable; valid as root_cnt

Behaviour:
- Reset (sync, high): state IDLE; lambda_ready=1; err_valid=0, err_flag=0, err_pos=0, done=0, root_cnt=0, lambda_deg=0, fail=0; all term registers 0.
- Reset asserted mid-run: next edge returns to IDLE with the values above. No done pulse; the partial run is discarded.
- States:
  - IDLE: lambda_ready=1. On the edge where lambda_valid && lambda_ready, go to RUN.
  - RUN: err_valid=1.
  - DONE: one cycle, then IDLE.
- Accept edge (cycle c):
  - term_k <= Lambda_k * alpha^(k*(2^M-N) mod (2^M-1)) for k=1..T.
  - term_0 <= Lambda_0.
  - pos <= 0; root counter <= 0.
  - lambda_deg <= index of the highest nonzero Lambda_k (0 if all k≥1 are zero).
  - Constants are computed at elaboration from M, N, PRIM_POLY. Constant multipliers are combinational XOR networks.
- RUN, position j is presented from cycle c+1:
  - err_flag = (XOR of term_0..term_T == 0). Combinational from registers, no latency.
  - err_pos = j.
  - Meaning: err_flag=1 ⇔ Lambda(alpha^-(N-1-j)) = 0, i.e. the symbol at polynomial degree N-1-j is in error.
- Advance only on edges where err_valid && out_ready:
  - term_k <= term_k * alpha^k.
  - pos <= pos+1.
  - root counter += err_flag.
  - With out_ready=0, all state and outputs are held stable.
- Advance with pos==N-1: go to DONE; err_valid drops next cycle.
- DONE cycle:
  - done=1.
  - root_cnt = final count.
  - fail = (Lambda_0 == 0) || (root_cnt != lambda_deg).
  - root_cnt, lambda_deg and fail are held until the next accept.
- Back-to-back: a new polynomial is accepted no earlier than the IDLE cycle after DONE. Throughput is N+2 cycles per codeword with out_ready tied high.
- lambda_valid while not IDLE is ignored: lambda_ready=0 and no state change.
- All-zero Lambda: every position flags (err_flag=1 ×N); root_cnt=N; fail=1.
- Root counter width PW is never exceeded because N < 2^PW.

Test Plan:
- Lambda=1, others 0, N=255, out_ready=1:
  - 255 err_valid cycles, err_pos 0..254, err_flag=0 throughout.
  - done at c+256; root_cnt=0, lambda_deg=0, fail=0.
- Single error at received position 10 (degree 244): Lambda_0=1, Lambda_1=alpha^244.
  - err_flag=1 only at err_pos=10.
  - root_cnt=1, lambda_deg=1, fail=0.
- Two errors at positions 0 and 254: Lambda = (1+alpha^254 x)(1+alpha^0 x).
  - Flags at err_pos 0 and 254 only.
  - root_cnt=2, fail=0.
  - Repeat with N=204 (shortened), errors at positions 3 and 200: flags at exactly 3 and 200; done after 204 positions.
- Backpressure: out_ready toggled randomly, using the single-error case.
  - err_pos/err_flag are stable while out_ready=0.
  - Flag seen exactly once, at pos 10.
  - Accepted-position count is 255.
- Degree-2 Lambda with no roots in the shortened range (e.g. roots at degrees ≥ N for N=204):
  - No flags; root_cnt=0, lambda_deg=2, fail=1.
  - Lambda_0=0 variant also gives fail=1.
- sys_rst asserted at pos=100:
  - Next cycle: err_valid=0, lambda_ready=1, done never pulses, all outputs 0.
  - A new accept afterward runs cleanly from pos 0.
  - lambda_valid held high during RUN is not accepted until after DONE.

Source files
------------

// File: rtl/chien_search_param_if.sv
// Handshake and result bundle between the BM stage, the Chien search and the
// correction stage. The slave side is the Chien search block.
interface chien_search_param_if #(
   parameter int M  = 8,
   parameter int T  = 8,
   parameter int PW = 8
) ();
   logic [(T+1)*M-1:0] lambda_in;
   logic               lambda_valid;
   logic               lambda_ready;
   logic               err_valid;
   logic               out_ready;
   logic               err_flag;
   logic [PW-1:0]      err_pos;
   logic               done;
   logic [PW-1:0]      root_cnt;
   logic [PW-1:0]      lambda_deg;
   logic               fail;

   modport master (
      output lambda_in, lambda_valid, out_ready,
      input  lambda_ready, err_valid, err_flag, err_pos, done, root_cnt, lambda_deg, fail
   );

   modport slave (
      input  lambda_in, lambda_valid, out_ready,
      output lambda_ready, err_valid, err_flag, err_pos, done, root_cnt, lambda_deg, fail
   );
endinterface

// File: rtl/chien_search_param.sv
// Chien search: evaluates the error locator at every codeword position in
// received order and streams one error flag per position with backpressure.
//
// state  | meaning
// IDLE   | waiting for a locator polynomial, lambda_ready high
// RUN    | presenting position r_pos, advancing on out_ready
// DONE   | one-cycle done pulse, results registered
module chien_search_param #(
   parameter int         M         = 8,
   parameter int         T         = 8,
   parameter int         N         = 255,
   parameter logic [M:0] PRIM_POLY = 9'h11D,
   parameter int         PW        = 8
) (
   input logic                 clk_in,
   input logic                 sys_rst,
   chien_search_param_if.slave cs_bus
);

   localparam int Q = (1 << M) - 1;

   typedef enum logic [1:0] {S_IDLE, S_RUN, S_DONE} state_t;

   // multiply by alpha (x) modulo the primitive polynomial
   function automatic logic [M-1:0] gf_xtime(input logic [M-1:0] a);
      logic [M-1:0] r;
      r = a << 1;
      if (a[M-1]) r = r ^ PRIM_POLY[M-1:0];
      return r;
   endfunction

   // general GF(2^M) product; with one constant operand it reduces to XORs
   function automatic logic [M-1:0] gf_mul(input logic [M-1:0] a, input logic [M-1:0] b);
      logic [M-1:0] acc;
      logic [M-1:0] sh;
      acc = '0;
      sh  = a;
      for (int i = 0; i < M; i++) begin
         if (b[i]) acc = acc ^ sh;
         sh = gf_xtime(sh);
      end
      return acc;
   endfunction

   // alpha^e by square-and-multiply, e < 2^M
   function automatic logic [M-1:0] alpha_pow(input int e);
      logic [M-1:0] res;
      logic [M-1:0] base;
      logic [31:0]  ev;
      ev      = 32'(e);
      res     = '0;
      res[0]  = 1'b1;
      base    = '0;
      base[1] = 1'b1;
      for (int i = 0; i < M; i++) begin
         if (ev[i]) res = gf_mul(res, base);
         base = gf_mul(base, base);
      end
      return res;
   endfunction

   state_t        r_state;
   state_t        w_next;
   logic [M-1:0]  r_term [0:T];
   logic [M-1:0]  w_lam  [0:T];
   logic [M-1:0]  w_init [0:T];
   logic [M-1:0]  w_step [0:T];
   logic [M-1:0]  w_sum;
   logic [PW-1:0] r_pos;
   logic [PW-1:0] r_cnt;
   logic [PW-1:0] r_root_cnt;
   logic [PW-1:0] r_deg;
   logic          r_fail;
   logic [PW-1:0] w_deg;
   logic [PW-1:0] w_cnt_next;
   logic          w_run;
   logic          w_flag;
   logic          w_accept;
   logic          w_advance;
   logic          w_last;

   // The initial scale skips the 2^M-1-N positions a shortened code never
   // transmits, so term k starts at Lambda_k * alpha^(-k*(N-1)).
   for (genvar k = 0; k <= T; k++) begin : g_term
      localparam logic [M-1:0] C_INIT = alpha_pow((k * ((1 << M) - N)) % Q);
      localparam logic [M-1:0] C_STEP = alpha_pow(k % Q);
      assign w_lam[k]  = cs_bus.lambda_in[k*M +: M];
      assign w_init[k] = gf_mul(w_lam[k], C_INIT);
      assign w_step[k] = gf_mul(r_term[k], C_STEP);
   end

   // locator degree: index of the highest nonzero coefficient above Lambda_0
   always_comb begin
      w_deg = '0;
      for (int k = 1; k <= T; k++)
         if (w_lam[k] != '0) w_deg = PW'(k);
   end

   // Lambda evaluated at the current position
   always_comb begin
      w_sum = '0;
      for (int k = 0; k <= T; k++) w_sum = w_sum ^ r_term[k];
   end

   assign w_run      = (r_state == S_RUN);
   assign w_flag     = w_run && (w_sum == '0);
   assign w_accept   = cs_bus.lambda_valid && (r_state == S_IDLE);
   assign w_advance  = w_run && cs_bus.out_ready;
   assign w_last     = (r_pos == PW'(N - 1));
   assign w_cnt_next = r_cnt + {{(PW-1){1'b0}}, w_flag};

   assign cs_bus.lambda_ready = (r_state == S_IDLE);
   assign cs_bus.err_valid    = w_run;
   assign cs_bus.err_flag     = w_flag;
   assign cs_bus.err_pos      = w_run ? r_pos : '0;
   assign cs_bus.done         = (r_state == S_DONE);
   assign cs_bus.root_cnt     = r_root_cnt;
   assign cs_bus.lambda_deg   = r_deg;
   assign cs_bus.fail         = r_fail;

   // state register
   always_ff @(posedge clk_in) begin
      if (sys_rst) r_state <= S_IDLE;
      else         r_state <= w_next;
   end

   // next-state logic
   always_comb begin
      w_next = r_state;
      case (r_state)
         S_IDLE:  if (w_accept) w_next = S_RUN;
         S_RUN:   if (w_advance && w_last) w_next = S_DONE;
         S_DONE:  w_next = S_IDLE;
         default: w_next = S_IDLE;
      endcase
   end

   // term registers, position, root counter and registered results
   always_ff @(posedge clk_in) begin
      if (sys_rst) begin
         for (int k = 0; k <= T; k++) r_term[k] <= '0;
         r_pos      <= '0;
         r_cnt      <= '0;
         r_root_cnt <= '0;
         r_deg      <= '0;
         r_fail     <= 1'b0;
      end else if (w_accept) begin
         for (int k = 0; k <= T; k++) r_term[k] <= w_init[k];
         r_pos <= '0;
         r_cnt <= '0;
         r_deg <= w_deg;
      end else if (w_advance) begin
         for (int k = 0; k <= T; k++) r_term[k] <= w_step[k];
         r_pos <= r_pos + 1'b1;
         r_cnt <= w_cnt_next;
         if (w_last) begin
            r_root_cnt <= w_cnt_next;
            // term 0 never rotates, so it still holds Lambda_0
            r_fail     <= (r_term[0] == '0) || (w_cnt_next != r_deg);
         end
      end
   end

endmodule
